time_of_day_counter: RTL and testbench
======================================

Name: time_of_day_counter

Overview:
Parametrised successor to the flat fraction-count timekeeper. It holds time of day as separate fraction/seconds/minutes/hours fields with ripple carry, and supports field-wise increment, decrement and parallel load for the set-time UI. It also emits carry pulses. It sits between the tick prescaler and the display/alarm-compare logic.

Parameters:
TICKS_PER_SEC, 100, fraction ticks per second (2..2**FRAC_WIDTH).
FRAC_WIDTH, 7, width of the fraction field.
HOURS_PER_DAY, 24, hour modulus (2..32).
START_HOURS, 0, reset value of the hours field.
START_MINUTES, 0, reset value of the minutes field.
START_SECONDS, 0, reset value of the seconds field.

Ports:
i_Clk  in  1  system clock; all state updates on its rising edge
i_Reset_n  in  1  asynchronous, active-low reset
i_Enable  in  1  qualifies i_Tick and all inc/dec strobes
i_Tick  in  1  one-cycle fraction-advance strobe
i_Minutes_Inc  in  1  minutes +1 (set mode)
i_Minutes_Dec  in  1  minutes -1 (set mode)
i_Hours_Inc  in  1  hours +1
i_Hours_Dec  in  1  hours -1
i_Load  in  1  parallel load strobe
i_Load_Hours  in  5  load value for hours
i_Load_Minutes  in  6  load value for minutes
i_Load_Seconds  in  6  load value for seconds
o_Fraction  out  FRAC_WIDTH  fraction field
o_Seconds  out  6  seconds field, 0..59
o_Minutes  out  6  minutes field, 0..59
o_Hours  out  5  hours field, 0..HOURS_PER_DAY-1
o_Second_Pulse  out  1  registered pulse on a fraction->seconds carry
o_Minute_Pulse  out  1  registered pulse on a seconds->minutes carry
o_Day_Wrap  out  1  registered pulse on an hours wrap to 0 caused by a tick carry

Behaviour:
- Reset: the clock's reset is asynchronous, active-low (i_Reset_n). While it is low:
  - fraction = 0, seconds = START_SECONDS, minutes = START_MINUTES, hours = START_HOURS.
  - All pulse outputs are 0.
  - Reset asserted mid-operation overrides everything immediately.
- Priority each cycle: reset > i_Load > i_Enable > hold.
- i_Load:
  - Fraction is cleared to 0.
  - Each loaded field is clamped: a value above its max saturates to the max (59, or HOURS_PER_DAY-1).
  - Load ignores i_Enable. Pulses are 0 in the load cycle.
- i_Enable = 0: all fields hold; pulses are 0.
- i_Enable = 1, tick path:
  - i_Tick adds 1 to fraction. At TICKS_PER_SEC-1, fraction wraps to 0 and seconds +1.
  - Seconds 59 wraps to 0 and minutes +1; minutes 59 wraps to 0 and hours +1; hours HOURS_PER_DAY-1 wraps to 0.
  - The whole carry chain resolves in a single cycle.
- i_Enable = 1, adjust path (applied after the tick result in the same cycle):
  - Minutes inc/dec wrap modulo 60 and never carry or borrow into hours.
  - Hours inc/dec wrap modulo HOURS_PER_DAY.
  - Inc and Dec of the same field asserted together: no adjustment to that field.
  - A tick carry into a field and an inc of that field in the same cycle: both apply (net +2, modulo).
  - A tick carry and a dec of the same field in the same cycle: net 0.
- Pulses:
  - Registered; asserted in the cycle after the carry, i.e. together with the updated field value; one cycle wide.
  - Generated only by the tick path, never by the adjust path or by load.
- Latency: every field change is visible one clock after the qualifying strobe edge.
- Fraction does not change on inc/dec.

Optional Feature:
Macro TIME_OF_DAY_COUNTER_12H_EN.
- Defined: adds outputs o_Hours_12 (5 bits, 1..12) and o_PM (1 bit), combinationally derived from hours (0 -> 12 AM, 12 -> 12 PM, 13 -> 1 PM). Valid only for HOURS_PER_DAY = 24; for any other value, elaboration fails via a generate-time error.
- Undefined: these ports do not exist; all other behaviour is identical.

Decomposition:
- Shared package/header:
  - SEC_PER_MIN = 60, MIN_PER_HOUR = 60.
  - Field widths 6/6/5.
  - Field-select enum used by the alarm block: FIELD_SEC, FIELD_MIN, FIELD_HOUR.
- One natural sub-module: mod_n_field_counter.
  - Parameters: modulus and width.
  - Inputs: carry-in, inc, dec, load, load value.
  - Outputs: value, carry-out.
  - Instantiated four times (fraction, seconds, minutes, hours).

Test Plan:
1. Reset with START_HOURS=7, START_MINUTES=30 -> outputs 07:30:00.00, all pulses 0; release reset, no strobes -> hold.
2. Load 23:59:59, then 99 ticks with TICKS_PER_SEC=100 -> fraction 99; one more tick -> 00:00:00.00, with o_Second_Pulse, o_Minute_Pulse and o_Day_Wrap high for exactly one cycle.
3. Minutes 59, i_Minutes_Inc -> minutes 0 and hours unchanged; hours 0, i_Hours_Dec -> hours 23; no pulses.
4. Load 31/63/63 -> clamped to 23:59:59; fraction 0; no pulses.
5. Inc+Dec of minutes together -> no change. Tick carry into minutes plus i_Minutes_Inc in the same cycle at 10:20:59.99 -> 10:22:00.00.
6. Assert i_Reset_n low mid-count between clock edges -> outputs return to START values immediately. i_Enable=0 with ticks -> no change.

Source files
------------

// File: rtl/time_of_day_counter_pkg.sv
// rtl/time_of_day_counter_pkg.sv - shared constants, field widths and field-select enum for the time-of-day counter
package time_of_day_counter_pkg;

    localparam int SEC_PER_MIN  = 60;
    localparam int MIN_PER_HOUR = 60;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    typedef enum logic [1:0] {
        FIELD_SEC,
        FIELD_MIN,
        FIELD_HOUR
    } field_sel_e;

endpackage

// File: rtl/time_of_day_counter_field.sv
// rtl/time_of_day_counter_field.sv - mod-N field counter with carry-in, inc/dec adjust and clamped parallel load
module mod_n_field_counter #(
    parameter int MODULUS     = 60,
    parameter int WIDTH       = 6,
    parameter int RESET_VALUE = 0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             carry_i,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    output logic [WIDTH-1:0] value_o,
    output logic             carry_o
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] value_q, value_d;
    logic [WIDTH:0]   plus2;
    logic             inc_eff, dec_eff;

    // Inc and dec together cancel; a carry-in stacks with inc or cancels a dec.
    always_comb begin
        inc_eff = inc_i & ~dec_i;
        dec_eff = dec_i & ~inc_i;
        plus2   = {1'b0, value_q} + (WIDTH + 1)'(2);
        value_d = value_q;
        if (load_i) begin
            value_d = (load_value_i > MAX_VAL) ? MAX_VAL : load_value_i;
        end else begin
            case ({carry_i, inc_eff, dec_eff})
                3'b100, 3'b010: value_d = (value_q == MAX_VAL) ? '0 : value_q + 1'b1;
                3'b110:         value_d = (plus2 >= MOD_EXT) ? WIDTH'(plus2 - MOD_EXT)
                                                             : plus2[WIDTH-1:0];
                3'b001:         value_d = (value_q == '0) ? MAX_VAL : value_q - 1'b1;
                default:        value_d = value_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            value_q <= WIDTH'(RESET_VALUE);
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;
    assign carry_o = carry_i & (value_q == MAX_VAL);

endmodule

// File: rtl/time_of_day_counter.sv
// rtl/time_of_day_counter.sv - hh:mm:ss.frac timekeeper with ripple carry, set-time adjust, load and carry pulses; 12-hour outputs under TIME_OF_DAY_COUNTER_12H_EN
module time_of_day_counter
    import time_of_day_counter_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100,
    parameter int FRAC_WIDTH    = 7,
    parameter int HOURS_PER_DAY = 24,
    parameter int START_HOURS   = 0,
    parameter int START_MINUTES = 0,
    parameter int START_SECONDS = 0
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset_n,
    input  logic                  i_Enable,
    input  logic                  i_Tick,
    input  logic                  i_Minutes_Inc,
    input  logic                  i_Minutes_Dec,
    input  logic                  i_Hours_Inc,
    input  logic                  i_Hours_Dec,
    input  logic                  i_Load,
    input  logic [HOUR_W-1:0]     i_Load_Hours,
    input  logic [MIN_W-1:0]      i_Load_Minutes,
    input  logic [SEC_W-1:0]      i_Load_Seconds,
    output logic [FRAC_WIDTH-1:0] o_Fraction,
    output logic [SEC_W-1:0]      o_Seconds,
    output logic [MIN_W-1:0]      o_Minutes,
    output logic [HOUR_W-1:0]     o_Hours,
    output logic                  o_Second_Pulse,
    output logic                  o_Minute_Pulse,
    output logic                  o_Day_Wrap
`ifdef TIME_OF_DAY_COUNTER_12H_EN
    ,
    output logic [4:0]            o_Hours_12,
    output logic                  o_PM
`endif
);

    logic adv, tick_c;
    logic frac_carry, sec_carry, min_carry, hour_carry;
    logic second_pulse_q, minute_pulse_q, day_wrap_q;

    // Load outranks enable, so the tick and adjust paths are muted during a load.
    assign adv    = i_Enable & ~i_Load;
    assign tick_c = adv & i_Tick;

    mod_n_field_counter #(
        .MODULUS(TICKS_PER_SEC), .WIDTH(FRAC_WIDTH), .RESET_VALUE(0)
    ) u_fraction (
        .clk_i(i_Clk), .rst_n_i(i_Reset_n), .carry_i(tick_c),
        .inc_i(1'b0), .dec_i(1'b0), .load_i(i_Load), .load_value_i('0),
        .value_o(o_Fraction), .carry_o(frac_carry)
    );

    mod_n_field_counter #(
        .MODULUS(SEC_PER_MIN), .WIDTH(SEC_W), .RESET_VALUE(START_SECONDS)
    ) u_seconds (
        .clk_i(i_Clk), .rst_n_i(i_Reset_n), .carry_i(frac_carry),
        .inc_i(1'b0), .dec_i(1'b0), .load_i(i_Load), .load_value_i(i_Load_Seconds),
        .value_o(o_Seconds), .carry_o(sec_carry)
    );

    mod_n_field_counter #(
        .MODULUS(MIN_PER_HOUR), .WIDTH(MIN_W), .RESET_VALUE(START_MINUTES)
    ) u_minutes (
        .clk_i(i_Clk), .rst_n_i(i_Reset_n), .carry_i(sec_carry),
        .inc_i(adv & i_Minutes_Inc), .dec_i(adv & i_Minutes_Dec),
        .load_i(i_Load), .load_value_i(i_Load_Minutes),
        .value_o(o_Minutes), .carry_o(min_carry)
    );

    mod_n_field_counter #(
        .MODULUS(HOURS_PER_DAY), .WIDTH(HOUR_W), .RESET_VALUE(START_HOURS)
    ) u_hours (
        .clk_i(i_Clk), .rst_n_i(i_Reset_n), .carry_i(min_carry),
        .inc_i(adv & i_Hours_Inc), .dec_i(adv & i_Hours_Dec),
        .load_i(i_Load), .load_value_i(i_Load_Hours),
        .value_o(o_Hours), .carry_o(hour_carry)
    );

    // Carry-outs come only from the tick chain, so adjust and load never pulse.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            second_pulse_q <= 1'b0;
            minute_pulse_q <= 1'b0;
            day_wrap_q     <= 1'b0;
        end else begin
            second_pulse_q <= frac_carry;
            minute_pulse_q <= sec_carry;
            day_wrap_q     <= hour_carry;
        end
    end

    assign o_Second_Pulse = second_pulse_q;
    assign o_Minute_Pulse = minute_pulse_q;
    assign o_Day_Wrap     = day_wrap_q;

`ifdef TIME_OF_DAY_COUNTER_12H_EN
    if (HOURS_PER_DAY != 24) begin : g_bad_hours_per_day
        $error("time_of_day_counter: 12-hour outputs require HOURS_PER_DAY == 24");
    end

    always_comb begin
        o_PM = (o_Hours >= 5'd12);
        if (o_Hours == 5'd0) begin
            o_Hours_12 = 5'd12;
        end else if (o_Hours > 5'd12) begin
            o_Hours_12 = o_Hours - 5'd12;
        end else begin
            o_Hours_12 = o_Hours;
        end
    end
`endif

endmodule

// File: tb/tb_time_of_day_counter.sv
// tb/tb_time_of_day_counter.sv - table-driven scoreboard bench for time_of_day_counter
module tb_time_of_day_counter;

    typedef struct packed {
        logic       load, en, tick, mi, md, hi, hd;
        logic [4:0] lh;
        logic [5:0] lm, ls;
    } in_t;

    typedef struct packed {
        logic [4:0] hr;
        logic [5:0] mn, sc;
        logic [6:0] fr;
        logic       sp, mp, dw;
    } out_t;

    typedef struct {
        string name;
        int    pre;
        in_t   in;
        out_t  exp;
    } vec_t;

    logic       clk, rst_n;
    logic       en, tick, mi, md, hi, hd, load;
    logic [4:0] lh;
    logic [5:0] lm, ls;
    logic [6:0] fr;
    logic [5:0] sc, mn;
    logic [4:0] hr;
    logic       sp, mp, dw;

    vec_t vecs[$];
    out_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    time_of_day_counter #(
        .TICKS_PER_SEC(100), .FRAC_WIDTH(7), .HOURS_PER_DAY(24),
        .START_HOURS(7), .START_MINUTES(30), .START_SECONDS(0)
    ) dut (
        .i_Clk(clk), .i_Reset_n(rst_n), .i_Enable(en), .i_Tick(tick),
        .i_Minutes_Inc(mi), .i_Minutes_Dec(md), .i_Hours_Inc(hi), .i_Hours_Dec(hd),
        .i_Load(load), .i_Load_Hours(lh), .i_Load_Minutes(lm), .i_Load_Seconds(ls),
        .o_Fraction(fr), .o_Seconds(sc), .o_Minutes(mn), .o_Hours(hr),
        .o_Second_Pulse(sp), .o_Minute_Pulse(mp), .o_Day_Wrap(dw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t out_at(int h, int m, int s, int f, bit p_s, bit p_m, bit p_d);
        out_t o;
        o.hr = 5'(h); o.mn = 6'(m); o.sc = 6'(s); o.fr = 7'(f);
        o.sp = p_s; o.mp = p_m; o.dw = p_d;
        return o;
    endfunction

    function automatic in_t ctl(bit e, bit t, bit m_i, bit m_d, bit h_i, bit h_d);
        in_t i = '0;
        i.en = e; i.tick = t; i.mi = m_i; i.md = m_d; i.hi = h_i; i.hd = h_d;
        return i;
    endfunction

    function automatic in_t ld(int h, int m, int s, bit e, bit t);
        in_t i = '0;
        i.load = 1'b1; i.en = e; i.tick = t;
        i.lh = 5'(h); i.lm = 6'(m); i.ls = 6'(s);
        return i;
    endfunction

    task automatic add(string n, int pre, in_t i, out_t e);
        vec_t v;
        v.name = n; v.pre = pre; v.in = i; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic apply(in_t i);
        load = i.load; en = i.en; tick = i.tick;
        mi = i.mi; md = i.md; hi = i.hi; hd = i.hd;
        lh = i.lh; lm = i.lm; ls = i.ls;
    endtask

    task automatic check(string n);
        out_t e, a;
        a = {hr, mn, sc, fr, sp, mp, dw};
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: DUT output with no expected value queued", n);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                bad++;
                $display("FAIL %s: got %0d:%0d:%0d.%0d pulses=%b%b%b, expected %0d:%0d:%0d.%0d pulses=%b%b%b",
                         n, a.hr, a.mn, a.sc, a.fr, a.sp, a.mp, a.dw,
                         e.hr, e.mn, e.sc, e.fr, e.sp, e.mp, e.dw);
            end
        end
    endtask

    task automatic step(string n, in_t i, out_t e);
        apply(i);
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        check(n);
        apply('0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        out_t start_t, prev, e;

        start_t = out_at(7, 30, 0, 0, 0, 0, 0);
        add("hold_noen",        0,  ctl(0, 0, 0, 0, 0, 0), start_t);
        add("hold_en",          0,  ctl(1, 0, 0, 0, 0, 0), start_t);
        add("tick_noen",        0,  ctl(0, 1, 0, 0, 0, 0), start_t);
        add("load_235959",      0,  ld(23, 59, 59, 1, 0),  out_at(23, 59, 59, 0, 0, 0, 0));
        add("day_wrap",         99, ctl(1, 1, 0, 0, 0, 0), out_at(0, 0, 0, 0, 1, 1, 1));
        add("pulse_clear",      0,  ctl(1, 0, 0, 0, 0, 0), out_at(0, 0, 0, 0, 0, 0, 0));
        add("load_005900",      0,  ld(0, 59, 0, 1, 0),    out_at(0, 59, 0, 0, 0, 0, 0));
        add("min_inc_wrap",     0,  ctl(1, 0, 1, 0, 0, 0), out_at(0, 0, 0, 0, 0, 0, 0));
        add("hr_dec_wrap",      0,  ctl(1, 0, 0, 0, 0, 1), out_at(23, 0, 0, 0, 0, 0, 0));
        add("hr_inc_wrap",      0,  ctl(1, 0, 0, 0, 1, 0), out_at(0, 0, 0, 0, 0, 0, 0));
        add("min_dec_wrap",     0,  ctl(1, 0, 0, 1, 0, 0), out_at(0, 59, 0, 0, 0, 0, 0));
        add("load_clamp",       0,  ld(31, 63, 63, 1, 0),  out_at(23, 59, 59, 0, 0, 0, 0));
        add("min_inc_dec",      0,  ctl(1, 0, 1, 1, 0, 0), out_at(23, 59, 59, 0, 0, 0, 0));
        add("hr_inc_dec",       0,  ctl(1, 0, 0, 0, 1, 1), out_at(23, 59, 59, 0, 0, 0, 0));
        add("inc_noen",         0,  ctl(0, 0, 1, 0, 1, 0), out_at(23, 59, 59, 0, 0, 0, 0));
        add("load_noen",        0,  ld(10, 20, 59, 0, 1),  out_at(10, 20, 59, 0, 0, 0, 0));
        add("tick_plus_inc",    99, ctl(1, 1, 1, 0, 0, 0), out_at(10, 22, 0, 0, 1, 1, 0));
        add("load_102059",      0,  ld(10, 20, 59, 1, 0),  out_at(10, 20, 59, 0, 0, 0, 0));
        add("tick_plus_dec",    99, ctl(1, 1, 0, 1, 0, 0), out_at(10, 20, 0, 0, 1, 1, 0));
        add("inc_keeps_frac",   3,  ctl(1, 0, 1, 0, 0, 0), out_at(10, 21, 0, 3, 0, 0, 0));
        add("load_clears_frac", 0,  ld(5, 6, 7, 1, 1),     out_at(5, 6, 7, 0, 0, 0, 0));
        add("sec_carry",        99, ctl(1, 1, 0, 0, 0, 0), out_at(5, 6, 8, 0, 1, 0, 0));

        rst_n = 1'b0;
        apply('0);
        #12;
        exp_q.push_back(start_t);
        check("reset_values");
        @(negedge clk);
        rst_n = 1'b1;

        prev = start_t;
        foreach (vecs[v]) begin
            for (int k = 0; k < vecs[v].pre; k++) begin
                e = prev;
                e.fr = 7'(int'(prev.fr) + k + 1);
                e.sp = 1'b0; e.mp = 1'b0; e.dw = 1'b0;
                step({vecs[v].name, "_pretick"}, ctl(1, 1, 0, 0, 0, 0), e);
            end
            step(vecs[v].name, vecs[v].in, vecs[v].exp);
            prev = vecs[v].exp;
        end

        // Reset dropped between clock edges must take effect without waiting for a clock.
        apply(ctl(1, 1, 0, 0, 0, 0));
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(start_t);
        check("async_reset_midcycle");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_reset_tick_noen", ctl(0, 1, 0, 0, 0, 0), start_t);
        step("post_reset_first_tick", ctl(1, 1, 0, 0, 0, 0), out_at(7, 30, 0, 1, 0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
